// File: rtl/fnd_pkg.sv
// Shared definitions for the multiplexed 7-segment display: font codes, dp bit position, BCD type.
package fnd_pkg;

    typedef logic [3:0] bcd_t;

    localparam int DP_BIT = 7;

    // Active-low segments, bit7 = dp (off), bits6..0 = g..a.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h98;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

endpackage

// File: rtl/fnd_font_rom.sv
// BCD to active-low 7-segment font; non-decimal codes show nothing.
module fnd_font_rom
    import fnd_pkg::*;
(
    input  bcd_t       bcd,
    output logic [7:0] font
);

    always_comb begin
        case (bcd)
            4'd0:    font = FONT_0;
            4'd1:    font = FONT_1;
            4'd2:    font = FONT_2;
            4'd3:    font = FONT_3;
            4'd4:    font = FONT_4;
            4'd5:    font = FONT_5;
            4'd6:    font = FONT_6;
            4'd7:    font = FONT_7;
            4'd8:    font = FONT_8;
            4'd9:    font = FONT_9;
            default: font = FONT_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 7-segment scanner with per-frame input snapshot, dead-time slots,
// leading-zero blanking and per-digit blinking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int NUM_SRC      = 2,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125,
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [4*NUM_DIGITS*NUM_SRC-1:0] i_value,
    input  logic [SEL_W-1:0]                i_sel,
    input  logic [NUM_DIGITS-1:0]           i_dp,
    input  logic                            i_blank_lz,
    input  logic [NUM_DIGITS-1:0]           i_blink,
    output logic [NUM_DIGITS-1:0]           o_digit,
    output logic [7:0]                      o_font,
    output logic                            o_frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]            cnt_reg;
    logic [IDX_W-1:0]            idx_reg;
    logic [FRM_W-1:0]            frame_cnt_reg;
    logic                        blink_phase_reg;
    bcd_t [NUM_DIGITS-1:0]       snap_digit_reg;
    logic [NUM_DIGITS-1:0]       snap_dp_reg;
    logic [NUM_DIGITS-1:0]       snap_blink_reg;
    logic                        snap_lz_reg;
    logic [NUM_DIGITS-1:0]       digit_reg;
    logic [7:0]                  font_reg;

    logic                        slot_end;
    logic                        last_digit;
    logic                        frame_start;
    bcd_t [NUM_DIGITS-1:0]       src_digits;
    logic [NUM_DIGITS-1:0]       lz_blank;
    logic                        zero_run;
    logic [NUM_DIGITS-1:0]       digit_next;
    logic [7:0]                  rom_font;
    logic [7:0]                  font_next;

    assign slot_end     = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign last_digit   = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign frame_start  = (cnt_reg == '0) && (idx_reg == '0);
    assign o_frame_tick = frame_start & ~i_reset;
    assign o_digit      = digit_reg;
    assign o_font       = font_reg;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            src_digits[d] = i_value[4*d +: 4];
            for (int s = 1; s < NUM_SRC; s++) begin
                if (int'(i_sel) == s) begin
                    src_digits[d] = i_value[4*(s*NUM_DIGITS + d) +: 4];
                end
            end
        end
    end

    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            zero_run    = zero_run & (snap_digit_reg[d] == 4'd0);
            lz_blank[d] = zero_run & snap_lz_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
        assign digit_next[gi] = (idx_reg != IDX_W'(gi));
    end

    fnd_font_rom u_font_rom (
        .bcd  (snap_digit_reg[idx_reg]),
        .font (rom_font)
    );

    always_comb begin
        font_next         = rom_font;
        font_next[DP_BIT] = ~snap_dp_reg[idx_reg];
        if (lz_blank[idx_reg]) begin
            font_next[6:0] = 7'h7F;
        end
        if (blink_phase_reg && snap_blink_reg[idx_reg]) begin
            font_next = FONT_BLANK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_reg         <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            snap_digit_reg  <= '0;
            snap_dp_reg     <= '0;
            snap_blink_reg  <= '0;
            snap_lz_reg     <= 1'b0;
            digit_reg       <= '1;
            font_reg        <= FONT_BLANK;
        end else begin
            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= last_digit ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // Blink phase advances only between frames so a frame never changes mid-scan.
            if (slot_end && last_digit) begin
                if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end

            if (frame_start) begin
                snap_digit_reg <= src_digits;
                snap_dp_reg    <= i_dp;
                snap_blink_reg <= i_blink;
                snap_lz_reg    <= i_blank_lz;
            end

            // First cycle of each slot is dead time so the previous digit cannot ghost.
            if (cnt_reg == '0) begin
                digit_reg <= '1;
                font_reg  <= FONT_BLANK;
            end else begin
                digit_reg <= digit_next;
                font_reg  <= font_next;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed and random stimulus for fnd_scan_controller, checked every cycle against a
// frame/slot arithmetic model of the display.
module tb_fnd_scan_controller;

    localparam int ND = 4;
    localparam int NS = 2;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   value;
    logic [0:0]    sel;
    logic [3:0]    dp;
    logic          blank_lz;
    logic [3:0]    blink;
    logic [3:0]    o_digit;
    logic [7:0]    o_font;
    logic          o_frame_tick;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .NUM_DIGITS   (ND),
        .NUM_SRC      (NS),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_value      (value),
        .i_sel        (sel),
        .i_dp         (dp),
        .i_blank_lz   (blank_lz),
        .i_blink      (blink),
        .o_digit      (o_digit),
        .o_font       (o_font),
        .o_frame_tick (o_frame_tick)
    );

    logic [7:0] font_tab [10];
    logic [3:0] m_dig [ND];
    logic [3:0] m_dp;
    logic [3:0] m_blink;
    logic       m_lz;
    logic [3:0] exp_digit;
    logic [7:0] exp_font;
    logic       exp_tick;
    int         t;
    int         n_total;
    int         n_pass;
    int         n_frames;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, want);
    endtask

    // Expected display for the slot cycle t, using the snapshot of its frame.
    task automatic predict(input int tc);
        int  idx;
        int  phase;
        bit  all_zero;
        logic [6:0] seg;
        idx   = (tc / SD) % ND;
        phase = ((tc / FRAME) / BF) % 2;
        exp_digit = 4'hF & ~(4'b0001 << idx);
        seg = (m_dig[idx] <= 4'd9) ? font_tab[m_dig[idx]][6:0] : 7'h7F;
        all_zero = 1'b1;
        for (int d = idx; d < ND; d++) begin
            if (m_dig[d] != 4'd0) all_zero = 1'b0;
        end
        if (m_lz && idx > 0 && all_zero) seg = 7'h7F;
        exp_font = {~m_dp[idx], seg};
        if (phase == 1 && m_blink[idx]) exp_font = 8'hFF;
    endtask

    task automatic cycle();
        logic [15:0] src;
        @(negedge clk);
        exp_tick = !rst && (t % FRAME == 0);
        check("digit", {4'h0, o_digit}, {4'h0, exp_digit});
        check("font",  o_font, exp_font);
        check("tick",  {7'h0, o_frame_tick}, {7'h0, exp_tick});
        if (rst) begin
            exp_digit = 4'hF;
            exp_font  = 8'hFF;
            t = 0;
        end else begin
            if (t % FRAME == 0) begin
                src = (int'(sel) < NS) ? value[16*int'(sel) +: 16] : value[15:0];
                for (int d = 0; d < ND; d++) m_dig[d] = src[4*d +: 4];
                m_dp    = dp;
                m_blink = blink;
                m_lz    = blank_lz;
                n_frames++;
                $display("frame %0d: sel=%0d digits=%h dp=%b blink=%b lz=%0d", n_frames, sel, src, dp, blink, blank_lz);
            end
            if (t % SD == 0) begin
                exp_digit = 4'hF;
                exp_font  = 8'hFF;
            end else begin
                predict(t);
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [3:0] rnd_digit();
        int r;
        r = $urandom_range(0, 15);
        if (r < 5) return 4'd0;
        if (r < 14) return 4'($urandom_range(1, 9));
        return 4'($urandom_range(10, 15));
    endfunction

    initial begin
        font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};
        for (int d = 0; d < ND; d++) m_dig[d] = 4'd0;
        m_dp = '0; m_blink = '0; m_lz = 1'b0;
        exp_digit = 4'hF; exp_font = 8'hFF; exp_tick = 1'b0;
        t = 0; n_total = 0; n_pass = 0; n_frames = 0;

        rst = 1'b1; value = 32'h0000_1234; sel = 1'b0; dp = '0; blank_lz = 1'b0; blink = '0;
        @(posedge clk);
        #1;
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        value[15:0] = 16'h0007; blank_lz = 1'b1;
        run(2 * FRAME);
        blank_lz = 1'b0;
        run(2 * FRAME);

        // Select change lands mid-frame; the frame in flight must keep source 0.
        value = 32'h5908_1234;
        run(2 * SD);
        sel = 1'b1;
        run(FRAME - 2 * SD + 2 * FRAME);

        sel = 1'b0; blink = 4'b0001;
        run(6 * FRAME);
        blink = 4'b0000;

        dp = 4'b0100; value[15:0] = 16'h0C00;
        run(FRAME + 6);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * FRAME);

        for (int it = 0; it < 40; it++) begin
            run($urandom_range(1, 20));
            for (int d = 0; d < 2 * ND; d++) value[4*d +: 4] = rnd_digit();
            sel      = 1'($urandom_range(0, 1));
            dp       = 4'($urandom_range(0, 15));
            blink    = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 2));
                rst = 1'b0;
            end
        end
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
